// File: rtl/fifo_rr_scheduler.sv
// Frame-aware round-robin drain of N ingress FIFOs onto one egress stream.
// Grants one port per frame; a 2-entry skid buffer absorbs read latency.
module fifo_rr_scheduler #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_FRAME  = 1522,
  localparam int PORT_W    = $clog2(N_PORTS)
) (
  input  logic                              rclk,
  input  logic                              rrst_n,
  input  logic [N_PORTS-1:0]                cfg_port_en,
  input  logic [N_PORTS-1:0]                fifo_empty,
  output logic [N_PORTS-1:0]                fifo_rd_en,
  input  logic [N_PORTS*(DATA_WIDTH+1)-1:0] fifo_rd_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_last,
  output logic [PORT_W-1:0]                 out_port,
  output logic                              busy,
  output logic                              err_trunc
);

  localparam int W    = DATA_WIDTH + 1;
  localparam int FC_W = $clog2(MAX_FRAME + 1);
  localparam int BW   = W + PORT_W;

  localparam logic [FC_W-1:0]   FC_LIM = FC_W'(MAX_FRAME - 1);
  localparam logic [PORT_W-1:0] LAST_P = PORT_W'(N_PORTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    XFER
  } state_t;

  state_t              state;
  logic [PORT_W-1:0]   rr_ptr;
  logic [PORT_W-1:0]   grant;
  logic [PORT_W-1:0]   arb_idx;
  logic                arb_hit;
  logic                pending;
  logic [FC_W-1:0]     frame_cnt;
  logic [BW-1:0]       mem [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          buf_cnt;
  logic [N_PORTS-1:0]  elig;
  logic [W-1:0]        cap_word;
  logic                cap_last;
  logic                at_lim;
  logic                stop;
  logic                trunc;
  logic                pop;
  logic                room;
  logic                rd_go;

  assign elig = ~fifo_empty & cfg_port_en;

  // Lowest rotation distance from rr_ptr wins.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = rr_ptr;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (elig[(int'(rr_ptr) + k) % N_PORTS]) begin
        arb_hit = 1'b1;
        arb_idx = PORT_W'((int'(rr_ptr) + k) % N_PORTS);
      end
    end
  end

  assign cap_word = fifo_rd_data[int'(grant)*W +: W];
  assign cap_last = cap_word[W-1];
  assign at_lim   = frame_cnt == FC_LIM;
  assign stop     = pending & (cap_last | at_lim);
  assign trunc    = pending & ~cap_last & at_lim;

  assign out_valid = buf_cnt != 2'd0;
  assign pop       = out_valid & out_ready;

  // Reserve a slot for the word returning next cycle.
  assign room  = (int'(buf_cnt) + int'(pending) - int'(pop)) < 2;
  assign rd_go = (state == XFER) & ~fifo_empty[grant] & ~stop & room;

  assign fifo_rd_en = rd_go ? (N_PORTS'(1) << grant) : '0;

  assign {out_port, out_last, out_data} = mem[rd_ptr];
  assign busy = (state != IDLE) | out_valid;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      pending   <= 1'b0;
      frame_cnt <= '0;
      err_trunc <= 1'b0;
    end else begin
      pending   <= rd_go;
      err_trunc <= trunc;
      unique case (state)
        IDLE: begin
          if (|elig) state <= ARB;
        end
        ARB: begin
          if (arb_hit) begin
            grant <= arb_idx;
            state <= XFER;
          end else begin
            state <= IDLE;
          end
        end
        XFER: begin
          if (stop) begin
            rr_ptr    <= (grant == LAST_P) ? '0 : grant + 1'b1;
            frame_cnt <= '0;
            state     <= ARB;
          end else if (pending) begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Truncated words are stored with last forced high.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      if (pending) begin
        mem[wr_ptr] <= {grant, cap_last | at_lim,
                        cap_word[DATA_WIDTH-1:0]};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      buf_cnt <= buf_cnt + {1'b0, pending} - {1'b0, pop};
    end
  end

endmodule
